// File: rtl/ternary_matvec.sv
// Ternary (-1/0/+1) matrix-vector multiply: streams one activation and one weight per cycle,
// accumulates each row at full width and writes the saturated result to the output memory.
package config_pkg;
  localparam int D = 8;
  localparam int FixedPointPrecision = 16;
endpackage

module ternary_matvec #(
  parameter int D = config_pkg::D,
  parameter int R = config_pkg::D,
  parameter int P = config_pkg::FixedPointPrecision,
  localparam int DW = $clog2(D),
  localparam int RW = (R > 1) ? $clog2(R) : 1,
  localparam int WW = $clog2(R * D)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          in_ready_o,
  input  logic          in_start_i,
  output logic          done_o,
  output logic [DW-1:0] vector_addr_o,
  input  logic [P-1:0]  vector_r_data_i,
  output logic [WW-1:0] weight_addr_o,
  input  logic [1:0]    weight_r_data_i,
  output logic [RW-1:0] out_addr_o,
  output logic          out_w_en_o,
  output logic [P-1:0]  out_w_data_o
);

  localparam int AW = P + DW + 1;
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-P+1){1'b0}}, {(P-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-P+1){1'b1}}, {(P-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, WRITE} state_t;

  state_t state_q, state_d;
  logic [RW-1:0] row_q;
  logic [DW-1:0] col_q;
  logic signed [AW-1:0] acc_q, acc_next, x_ext;
  logic last_col, last_row;

  assign last_col = (col_q == DW'(D - 1));
  assign last_row = (row_q == RW'(R - 1));
  assign x_ext    = AW'($signed(vector_r_data_i));

  // Codes 2'b00 and the reserved 2'b10 both leave the accumulator untouched.
  always_comb begin
    acc_next = acc_q;
    if (weight_r_data_i == 2'b01)      acc_next = acc_q + x_ext;
    else if (weight_r_data_i == 2'b11) acc_next = acc_q - x_ext;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    in_ready_o    = 1'b0;
    done_o        = 1'b0;
    vector_addr_o = '0;
    weight_addr_o = '0;
    out_addr_o    = '0;
    out_w_en_o    = 1'b0;
    out_w_data_o  = '0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_start_i) state_d = ACCUM;
      end
      ACCUM: begin
        vector_addr_o = col_q;
        weight_addr_o = WW'(row_q) * WW'(D) + WW'(col_q);
        if (last_col) state_d = WRITE;
      end
      WRITE: begin
        out_w_en_o = 1'b1;
        out_addr_o = row_q;
        if (acc_q > SAT_MAX)      out_w_data_o = SAT_MAX[P-1:0];
        else if (acc_q < SAT_MIN) out_w_data_o = SAT_MIN[P-1:0];
        else                      out_w_data_o = acc_q[P-1:0];
        if (last_row) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
      acc_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_start_i) begin
            row_q <= '0;
            col_q <= '0;
            acc_q <= '0;
          end
        end
        ACCUM: begin
          acc_q <= acc_next;
          col_q <= last_col ? '0 : col_q + 1'b1;
        end
        WRITE: begin
          acc_q <= '0;
          row_q <= last_row ? '0 : row_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_matvec.sv
// Self-checking bench for ternary_matvec: directed fixed-point cases, saturation, handshake,
// reset abort and random vectors checked against an integer dot-product model.
module tb_ternary_matvec;

  localparam int D  = 4;
  localparam int R  = 2;
  localparam int P  = 16;
  localparam int DW = $clog2(D);
  localparam int RW = (R > 1) ? $clog2(R) : 1;
  localparam int WW = $clog2(R * D);
  localparam int RUN_CYCLES = R * (D + 1);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_start_i = 1'b0;
  logic          in_ready_o, done_o, out_w_en_o;
  logic [DW-1:0] vector_addr_o;
  logic [P-1:0]  vector_r_data_i;
  logic [WW-1:0] weight_addr_o;
  logic [1:0]    weight_r_data_i;
  logic [RW-1:0] out_addr_o;
  logic [P-1:0]  out_w_data_o;

  logic [P-1:0] vec [D];
  logic [1:0]   wmem [R*D];
  logic [P-1:0] out_mem [R];
  int           wr_cycles[$];
  int           done_cycle;
  int           ready_cycles;
  int           checks = 0;
  int           errors = 0;

  assign vector_r_data_i = vec[vector_addr_o];
  assign weight_r_data_i = wmem[weight_addr_o];

  ternary_matvec #(.D(D), .R(R), .P(P)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_ready_o(in_ready_o), .in_start_i(in_start_i),
    .done_o(done_o), .vector_addr_o(vector_addr_o), .vector_r_data_i(vector_r_data_i),
    .weight_addr_o(weight_addr_o), .weight_r_data_i(weight_r_data_i),
    .out_addr_o(out_addr_o), .out_w_en_o(out_w_en_o), .out_w_data_o(out_w_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic longint weightValue(input logic [1:0] w);
    if (w == 2'b01) return 1;
    if (w == 2'b11) return -1;
    return 0;
  endfunction

  function automatic longint modelRow(input int r);
    longint s = 0;
    longint lim_hi = (longint'(1) <<< (P - 1)) - 1;
    longint lim_lo = -(longint'(1) <<< (P - 1));
    for (int c = 0; c < D; c++) begin
      longint xv = longint'($signed(vec[c]));
      s += weightValue(wmem[r*D + c]) * xv;
    end
    if (s > lim_hi) return lim_hi;
    if (s < lim_lo) return lim_lo;
    return s;
  endfunction

  // Cycle k = 0 is the first cycle after the edge that accepted the start.
  task automatic applyStimulus(input bit pulse_mid, input bit hold, input int window);
    wr_cycles.delete();
    done_cycle   = -1;
    ready_cycles = 0;
    for (int r = 0; r < R; r++) out_mem[r] = '0;
    @(negedge clk_i);
    in_start_i = 1'b1;
    @(negedge clk_i);
    for (int k = 0; k < window; k++) begin
      in_start_i = hold || (pulse_mid && (k == 1));
      if (out_w_en_o) begin
        out_mem[out_addr_o] = out_w_data_o;
        wr_cycles.push_back(k);
      end
      if (done_o && done_cycle < 0) done_cycle = k;
      if (in_ready_o) ready_cycles++;
      @(negedge clk_i);
    end
    in_start_i = 1'b0;
  endtask

  task automatic verifyRun(input string tag);
    checkOutput({tag, "_writes"}, wr_cycles.size(), R);
    checkOutput({tag, "_done_cycle"}, done_cycle, RUN_CYCLES - 1);
    for (int r = 0; r < R; r++) begin
      checkOutput({tag, "_row_val"}, longint'($signed(out_mem[r])), modelRow(r));
      if (r < wr_cycles.size())
        checkOutput({tag, "_row_cycle"}, wr_cycles[r], r*(D+1) + D);
    end
  endtask

  task automatic loadX(input int a, input int b, input int c, input int d);
    vec[0] = P'(a); vec[1] = P'(b); vec[2] = P'(c); vec[3] = P'(d);
  endtask

  initial begin
    for (int i = 0; i < D; i++) vec[i] = '0;
    for (int i = 0; i < R*D; i++) wmem[i] = 2'b00;
    repeat (2) @(negedge clk_i);
    checkOutput("reset_ready", in_ready_o, 1);
    checkOutput("reset_done", done_o, 0);
    checkOutput("reset_wen", out_w_en_o, 0);
    checkOutput("reset_addrs", {vector_addr_o, weight_addr_o, out_addr_o}, 0);
    checkOutput("reset_wdata", out_w_data_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("idle_ready", in_ready_o, 1);

    // Fixed point Q8.8: 1.0, 2.0, -0.5, 0.25
    loadX(256, 512, -128, 64);
    for (int c = 0; c < D; c++) begin wmem[c] = 2'b01; wmem[D + c] = 2'b00; end
    applyStimulus(1'b0, 1'b0, RUN_CYCLES + 3);
    verifyRun("all_plus");
    checkOutput("all_plus_out0", longint'($signed(out_mem[0])), 704);
    checkOutput("all_plus_out1", longint'($signed(out_mem[1])), 0);
    checkOutput("all_plus_ready_after", ready_cycles, 3);

    wmem[0] = 2'b01; wmem[1] = 2'b11; wmem[2] = 2'b10; wmem[3] = 2'b11;
    applyStimulus(1'b0, 1'b0, RUN_CYCLES + 3);
    verifyRun("mixed");
    checkOutput("mixed_out0", longint'($signed(out_mem[0])), -320);

    loadX(32767, 32767, 32767, 32767);
    for (int c = 0; c < D; c++) begin wmem[c] = 2'b01; wmem[D + c] = 2'b11; end
    applyStimulus(1'b0, 1'b0, RUN_CYCLES + 3);
    verifyRun("sat");
    checkOutput("sat_pos", longint'($signed(out_mem[0])), 32767);
    checkOutput("sat_neg", longint'($signed(out_mem[1])), -32768);

    // A start pulse during ACCUM must not queue a second run.
    loadX(256, 512, -128, 64);
    applyStimulus(1'b1, 1'b0, RUN_CYCLES + 6);
    verifyRun("pulse");
    checkOutput("pulse_ready_after", ready_cycles, 6);

    // Held start: the start seen on the done cycle is ignored, next run after one IDLE cycle.
    applyStimulus(1'b0, 1'b1, 2*RUN_CYCLES + 1);
    checkOutput("hold_writes", wr_cycles.size(), 2*R);
    checkOutput("hold_ready_cycles", ready_cycles, 1);
    for (int i = 0; i < wr_cycles.size() && i < 2*R; i++)
      checkOutput("hold_wr_cycle", wr_cycles[i],
                  (i / R) * (RUN_CYCLES + 1) + (i % R) * (D + 1) + D);
    repeat (3) @(negedge clk_i);
    checkOutput("hold_idle_after", in_ready_o, 1);

    for (int t = 0; t < 6; t++) begin
      for (int c = 0; c < D; c++) vec[c] = P'($urandom);
      if (t % 2 == 1) for (int c = 0; c < D; c++) vec[c] = P'($urandom_range(0, 511)) - P'(256);
      for (int i = 0; i < R*D; i++) wmem[i] = 2'($urandom);
      applyStimulus(1'b0, 1'b0, RUN_CYCLES + 3);
      verifyRun("random");
    end

    // Reset in the middle of ACCUM aborts without any further write.
    @(negedge clk_i);
    in_start_i = 1'b1;
    @(negedge clk_i);
    in_start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("midreset_wen", out_w_en_o, 0);
    checkOutput("midreset_ready", in_ready_o, 1);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("postreset_ready", in_ready_o, 1);
    begin
      int stray = 0;
      for (int k = 0; k < 2*RUN_CYCLES; k++) begin
        if (out_w_en_o || !in_ready_o) stray++;
        @(negedge clk_i);
      end
      checkOutput("postreset_quiet", stray, 0);
    end

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
